// File: rtl/uart_fifo_drain_ctrl_if.sv
// Read-side FIFO port plus transmitter valid/ready handshake seen by the drain controller.
// master = the drain controller, slave = the FIFO/transmitter environment.
interface uart_fifo_drain_ctrl_if #(
  parameter int FIFO_WIDTH = 8
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_n;
  logic [FIFO_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  fifo_empty, fifo_dout, tx_ready,
    output fifo_rd_n, tx_data, tx_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, tx_ready,
    input  fifo_rd_n, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_fifo_drain_ctrl.sv
// Sole reader of the UART FIFO: pops one byte, waits out the two-cycle read latency,
// and offers it to the transmitter on valid/ready. A level flush discards FIFO contents.
module uart_fifo_drain_ctrl #(
  parameter int FIFO_WIDTH = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   flush_i,
  uart_fifo_drain_ctrl_if.master bus,
  output logic                   busy_o,
  output logic [CNT_BITS-1:0]    tx_count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LAT   = 3'd2,
    S_CAP   = 3'd3,
    S_VALID = 3'd4,
    S_FLUSH = 3'd5
  } state_e;

  state_e                state_q;
  logic                  tx_valid_q;
  logic [FIFO_WIDTH-1:0] tx_data_q;
  logic [CNT_BITS-1:0]   tx_count_q;
  logic                  rd_n_d;

  // Control FSM with registered handshake outputs and delivered-byte counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            state_q <= S_FLUSH;
          end else if (enable_i && !bus.fifo_empty) begin
            state_q <= S_RD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        // A started read always runs through to capture, ignoring enable and flush.
        S_RD:  state_q <= S_LAT;
        S_LAT: state_q <= S_CAP;
        S_CAP: begin
          tx_data_q  <= bus.fifo_dout;
          tx_valid_q <= 1'b1;
          state_q    <= S_VALID;
        end
        S_VALID: begin
          if (bus.tx_ready) begin
            tx_count_q <= tx_count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
            tx_valid_q <= 1'b0;
            if (flush_i) begin
              state_q <= S_FLUSH;
            end else if (enable_i && !bus.fifo_empty) begin
              state_q <= S_RD;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (flush_i) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_FLUSH;
          end else begin
            state_q <= S_VALID;
          end
        end
        S_FLUSH: begin
          if (bus.fifo_empty && !flush_i) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_FLUSH;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Pop strobe: one pop in RD; in FLUSH pop every cycle the FIFO is not empty.
  always_comb begin
    rd_n_d = 1'b1;
    case (state_q)
      S_RD:    rd_n_d = 1'b0;
      S_FLUSH: rd_n_d = bus.fifo_empty;
      default: rd_n_d = 1'b1;
    endcase
  end

  assign bus.fifo_rd_n = rd_n_d;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign busy_o        = (state_q != S_IDLE);
  assign tx_count_o    = tx_count_q;

endmodule

// File: tb/tb_uart_fifo_drain_ctrl.sv
// Self-checking bench: behavioural FIFO, queue-based delivery scoreboard, directed
// latency/backpressure/flush/enable cases plus randomized traffic; second DUT for counter wrap.
module tb_uart_fifo_drain_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        fl  = 1'b0;
  logic        rdy = 1'b0;
  logic        busy, busy2;
  logic [15:0] cnt;
  logic [3:0]  cnt2;

  uart_fifo_drain_ctrl_if #(.FIFO_WIDTH(8)) bus ();
  uart_fifo_drain_ctrl_if #(.FIFO_WIDTH(8)) bus2 ();

  uart_fifo_drain_ctrl #(.FIFO_WIDTH(8), .CNT_BITS(16)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .flush_i(fl),
    .bus(bus.master), .busy_o(busy), .tx_count_o(cnt)
  );

  uart_fifo_drain_ctrl #(.FIFO_WIDTH(8), .CNT_BITS(4)) dut2 (
    .clock_i(clk), .reset_i(rst), .enable_i(1'b1), .flush_i(1'b0),
    .bus(bus2.master), .busy_o(busy2), .tx_count_o(cnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Behavioural FIFO: pop sampled at edge N loads RAM output, hold register loads at N+1.
  logic [7:0] mem[$];
  logic [7:0] pend[$];
  logic [7:0] ram_q = 8'h00;
  logic [7:0] dout_q = 8'h00;
  logic       pop_d1 = 1'b0;
  logic       empty_q = 1'b1;
  int         left2 = 0;
  int         cyc = 0;

  assign bus.fifo_empty  = empty_q;
  assign bus.fifo_dout   = dout_q;
  assign bus.tx_ready    = rdy;
  assign bus2.fifo_empty = (left2 == 0);
  assign bus2.fifo_dout  = 8'h3C;
  assign bus2.tx_ready   = 1'b1;

  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      cyc++;
      if (pop_d1) dout_q <= ram_q;
      if (!bus.fifo_rd_n && mem.size() > 0) begin
        b = mem.pop_front();
        ram_q  <= b;
        pop_d1 <= 1'b1;
      end else begin
        pop_d1 <= 1'b0;
      end
      while (pend.size() > 0) mem.push_back(pend.pop_front());
      empty_q <= (mem.size() == 0);
      if (rst) left2 <= 17;
      else if (!bus2.fifo_rd_n && left2 > 0) left2 <= left2 - 1;
    end
  end

  // Scoreboard: bytes expected in delivery order; flush and reset remove bytes from it.
  logic [7:0] exp_q[$];
  int pops[$];
  int hss[$];
  int vrise[$];
  int model_cnt = 0;
  int hs2 = 0;
  int last_pop = -100;

  initial begin
    logic       prev_hold = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_cnt = 0;
        hs2 = 0;
        last_pop = -100;
        prev_hold = 1'b0;
        prev_valid = 1'b0;
      end else begin
        check("tx_count", {16'h0, cnt}, model_cnt & 32'hFFFF);
        if (bus.tx_valid && rdy) begin
          if (exp_q.size() == 0) check("unexpected_hs", 32'd1, 32'd0);
          else check("tx_data", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
          hss.push_back(cyc);
          model_cnt++;
        end
        if (prev_hold) begin
          check("hold_valid", {31'h0, bus.tx_valid}, 32'd1);
          check("hold_data", {24'h0, bus.tx_data}, {24'h0, prev_data});
        end
        if (bus.tx_valid && !prev_valid) vrise.push_back(cyc);
        if (bus.tx_valid) check("busy_valid", {31'h0, busy}, 32'd1);
        if (!bus.fifo_rd_n) begin
          check("pop_nonempty", {31'h0, bus.fifo_empty}, 32'd0);
          if (!fl) check("pop_gap", ((cyc - last_pop) >= 4) ? 32'd1 : 32'd0, 32'd1);
          pops.push_back(cyc);
          last_pop = cyc;
        end
        if (fl) last_pop = -100;
        prev_hold  = bus.tx_valid && !rdy && !fl;
        prev_valid = bus.tx_valid;
        prev_data  = bus.tx_data;
        check("cnt2", {28'h0, cnt2}, hs2 % 16);
        if (bus2.tx_valid) begin
          check("data2", {24'h0, bus2.tx_data}, 32'h3C);
          check("busy2", {31'h0, busy2}, 32'd1);
          hs2++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] b);
    pend.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 100 && !bus.tx_valid; k++) step(1);
    check(tag, {31'h0, bus.tx_valid}, 32'd1);
  endtask

  task automatic do_flush(input string tag);
    logic [15:0] c0;
    c0 = cnt;
    rdy = 1'b0;
    fl  = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 300 && !bus.fifo_empty; k++) step(1);
    step(6);
    check({tag, "_empty"}, {31'h0, bus.fifo_empty}, 32'd1);
    check({tag, "_nvalid"}, {31'h0, bus.tx_valid}, 32'd0);
    check({tag, "_cnt"}, {16'h0, cnt}, {16'h0, c0});
    fl = 1'b0;
    step(2);
    check({tag, "_idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int base, hb, n;
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_valid", {31'h0, bus.tx_valid}, 32'd0);
    check("rst_rdn", {31'h0, bus.fifo_rd_n}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_data", {24'h0, bus.tx_data}, 32'd0);

    // Single byte: latency from pop to valid and to handshake.
    rdy = 1'b1;
    en  = 1'b1;
    push(8'hA5);
    for (int k = 0; k < 50 && hss.size() < 1; k++) step(1);
    step(2);
    check("one_hs", hss.size(), 32'd1);
    check("one_pops", pops.size(), 32'd1);
    if (hss.size() == 1 && pops.size() == 1 && vrise.size() == 1) begin
      check("lat_valid", vrise[0] - pops[0], 32'd3);
      check("lat_hs", hss[0] - pops[0], 32'd3);
    end
    check("one_cnt", {16'h0, cnt}, 32'd1);
    check("one_empty", {31'h0, bus.fifo_empty}, 32'd1);
    check("one_idle", {31'h0, busy}, 32'd0);

    // Five bytes back to back at peak rate.
    base = pops.size();
    hb = hss.size();
    for (int i = 1; i <= 5; i++) push(i[7:0]);
    for (int k = 0; k < 100 && hss.size() < hb + 5; k++) step(1);
    step(4);
    check("burst_pops", pops.size() - base, 32'd5);
    if (pops.size() >= base + 5)
      for (int i = 1; i < 5; i++) check("burst_gap", pops[base+i] - pops[base+i-1], 32'd4);
    check("burst_cnt", {16'h0, cnt}, 32'd6);

    // Backpressure: held byte, no pops, next pop right after the handshake.
    rdy = 1'b0;
    push(8'h11);
    push(8'h22);
    wait_valid("bp_valid");
    base = pops.size();
    step(10);
    check("bp_nopop", pops.size() - base, 32'd0);
    check("bp_data", {24'h0, bus.tx_data}, 32'h11);
    hb = hss.size();
    rdy = 1'b1;
    for (int k = 0; k < 20 && pops.size() <= base; k++) step(1);
    if (pops.size() > base && hss.size() > hb) check("bp_next_pop", pops[base] - hss[hb], 32'd1);
    else check("bp_next_pop_seen", 32'd0, 32'd1);
    step(8);

    // Flush: one byte held in VALID, twenty more in the FIFO.
    rdy = 1'b0;
    for (int i = 0; i < 21; i++) push(8'h40 + i[7:0]);
    wait_valid("fl_valid");
    base = pops.size();
    do_flush("fl");
    check("fl_pops", pops.size() - base, 32'd20);
    if (pops.size() >= base + 20) check("fl_consec", pops[base+19] - pops[base], 32'd19);

    // Enable dropped while the read is in LAT: byte still delivered, then idle.
    rdy = 1'b1;
    base = pops.size();
    hb = hss.size();
    push(8'h71);
    push(8'h72);
    push(8'h73);
    for (int k = 0; k < 20 && pops.size() <= base; k++) step(1);
    en = 1'b0;
    step(8);
    check("en_off_pops", pops.size() - base, 32'd1);
    check("en_off_hs", hss.size() - hb, 32'd1);
    check("en_off_idle", {31'h0, busy}, 32'd0);
    check("en_off_nonempty", {31'h0, bus.fifo_empty}, 32'd0);

    // Reset held two cycles while a byte waits in VALID: byte lost, all outputs cleared.
    rdy = 1'b0;
    en  = 1'b1;
    wait_valid("rst2_valid");
    void'(exp_q.pop_front());
    en  = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    check("rst2_valid", {31'h0, bus.tx_valid}, 32'd0);
    check("rst2_rdn", {31'h0, bus.fifo_rd_n}, 32'd1);
    check("rst2_busy", {31'h0, busy}, 32'd0);
    check("rst2_cnt", {16'h0, cnt}, 32'd0);

    // Randomized traffic with occasional flushes.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 9) begin
        do_flush("rfl");
      end else begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) push($urandom_range(0, 255));
        en  = ($urandom_range(0, 3) != 0);
        rdy = $urandom_range(0, 1);
        step($urandom_range(1, 8));
      end
    end

    en  = 1'b1;
    rdy = 1'b1;
    for (int k = 0; k < 1000 && (exp_q.size() != 0 || busy); k++) step(1);
    check("drain_left", exp_q.size(), 32'd0);
    check("drain_idle", {31'h0, busy}, 32'd0);
    check("drain_cnt", {16'h0, cnt}, model_cnt & 32'hFFFF);

    for (int k = 0; k < 200 && hs2 < 17; k++) step(1);
    step(3);
    check("wrap_hs", hs2, 32'd17);
    check("wrap_cnt", {28'h0, cnt2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
